mc_req_buffer: RTL

MC_REQ_BUFFER -- requests
Module: mc_req_buffer

---
 rtl/mc_req_buffer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mc_req_buffer.sv
// Request skid FIFO between the phold arbiter and one MC port, with read-outstanding throttling.
// Optional statistics counters are enabled by defining MC_REQ_STATS_EN.
module mc_req_buffer #(
  parameter int unsigned MC_RTNCTL_WIDTH = 32,
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned NB_DEPTH        = 3,
  parameter int unsigned SKID            = 2,
  parameter int unsigned MAX_RD_OUT      = 64,
  parameter int unsigned NB_RD_OUT       = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       up_rq_vld,
  input  logic [2:0]                 up_rq_cmd,
  input  logic [3:0]                 up_rq_scmd,
  input  logic [47:0]                up_rq_vadr,
  input  logic [1:0]                 up_rq_size,
  input  logic [MC_RTNCTL_WIDTH-1:0] up_rq_rtnctl,
  input  logic [63:0]                up_rq_data,
  input  logic                       up_rq_flush,
  output logic                       up_rq_stall,
  output logic                       mc_rq_vld,
  output logic [2:0]                 mc_rq_cmd,
  output logic [3:0]                 mc_rq_scmd,
  output logic [47:0]                mc_rq_vadr,
  output logic [1:0]                 mc_rq_size,
  output logic [MC_RTNCTL_WIDTH-1:0] mc_rq_rtnctl,
  output logic [63:0]                mc_rq_data,
  output logic                       mc_rq_flush,
  input  logic                       mc_rq_stall,
  input  logic                       mc_rs_vld,
  input  logic [2:0]                 mc_rs_cmd,
`ifdef MC_REQ_STATS_EN
  output logic [31:0]                stat_issued,
  output logic [31:0]                stat_stall_cyc,
`endif
  output logic [NB_RD_OUT-1:0]       rd_outstanding,
  output logic                       overflow
);

  localparam int unsigned CNT_W = NB_DEPTH + 1;

  typedef struct packed {
    logic                       flush;
    logic [63:0]                data;
    logic [MC_RTNCTL_WIDTH-1:0] rtnctl;
    logic [1:0]                 size;
    logic [47:0]                vadr;
    logic [3:0]                 scmd;
    logic [2:0]                 cmd;
  } req_t;

  req_t                 mem_q [DEPTH];
  req_t                 up_req_c, head_q, head_d;
  logic [CNT_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic                 vld_q, vld_d, stall_q, stall_d, ovf_q, ovf_d;
  logic [NB_RD_OUT-1:0] rd_out_q, rd_out_d;
  logic                 xfer_c, wr_en_c, rd_inc_c, rd_dec_c;

  always_comb begin
    up_req_c = '{flush: up_rq_flush, data: up_rq_data, rtnctl: up_rq_rtnctl, size: up_rq_size,
                 vadr: up_rq_vadr, scmd: up_rq_scmd, cmd: up_rq_cmd};
  end

  // Next-state: pointers, occupancy, throttle counter and registered head stage.
  always_comb begin
    xfer_c   = vld_q && !mc_rq_stall;
    wr_en_c  = up_rq_vld && ((count_q != CNT_W'(DEPTH)) || xfer_c);
    wr_ptr_d = wr_en_c ? wr_ptr_q + CNT_W'(1) : wr_ptr_q;
    rd_ptr_d = xfer_c ? rd_ptr_q + CNT_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (wr_en_c && !xfer_c) count_d = count_q + CNT_W'(1);
    else if (!wr_en_c && xfer_c) count_d = count_q - CNT_W'(1);
    ovf_d    = ovf_q || (up_rq_vld && !wr_en_c);

    rd_inc_c = xfer_c && (head_q.cmd == 3'd1);
    rd_dec_c = mc_rs_vld && (mc_rs_cmd == 3'd2);
    rd_out_d = rd_out_q;
    if (rd_inc_c && !rd_dec_c) rd_out_d = rd_out_q + NB_RD_OUT'(1);
    else if (rd_dec_c && !rd_inc_c && (rd_out_q != '0)) rd_out_d = rd_out_q - NB_RD_OUT'(1);

    // New head equals the entry being written when the buffer drains down to it.
    head_d = head_q;
    if (count_d != '0) begin
      if (wr_en_c && (rd_ptr_d == wr_ptr_q)) head_d = up_req_c;
      else head_d = mem_q[rd_ptr_d[NB_DEPTH-1:0]];
    end
    vld_d   = (count_d != '0) &&
              !((head_d.cmd == 3'd1) && (rd_out_d == NB_RD_OUT'(MAX_RD_OUT)));
    stall_d = (count_d >= CNT_W'(DEPTH - SKID));
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) mem_q[wr_ptr_q[NB_DEPTH-1:0]] <= up_req_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      vld_q    <= 1'b0;
      stall_q  <= 1'b0;
      ovf_q    <= 1'b0;
      rd_out_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      vld_q    <= vld_d;
      stall_q  <= stall_d;
      ovf_q    <= ovf_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign up_rq_stall    = stall_q;
  assign mc_rq_vld      = vld_q;
  assign mc_rq_cmd      = head_q.cmd;
  assign mc_rq_scmd     = head_q.scmd;
  assign mc_rq_vadr     = head_q.vadr;
  assign mc_rq_size     = head_q.size;
  assign mc_rq_rtnctl   = head_q.rtnctl;
  assign mc_rq_data     = head_q.data;
  assign mc_rq_flush    = head_q.flush;
  assign rd_outstanding = rd_out_q;
  assign overflow       = ovf_q;

`ifdef MC_REQ_STATS_EN
  logic [31:0] issued_q, issued_d, stall_cyc_q, stall_cyc_d;

  always_comb begin
    issued_d    = xfer_c ? issued_q + 32'd1 : issued_q;
    stall_cyc_d = (vld_q && mc_rq_stall) ? stall_cyc_q + 32'd1 : stall_cyc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_q    <= '0;
      stall_cyc_q <= '0;
    end else begin
      issued_q    <= issued_d;
      stall_cyc_q <= stall_cyc_d;
    end
  end

  assign stat_issued    = issued_q;
  assign stat_stall_cyc = stall_cyc_q;
`endif

endmodule
